// File: rtl/fetch_queue.sv
// Fetch stage: issues sequential imem requests under a credit limit, tags each with its PC,
// buffers in-order responses for decode and squashes in-flight responses on redirect.
module fetch_queue #(
    parameter int unsigned   N        = 64,
    parameter int unsigned   ILEN     = 32,
    parameter int unsigned   DEPTH    = 4,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            redirect_valid_i,
    input  logic [N-1:0]    redirect_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [N-1:0]    imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [ILEN-1:0] imem_rsp_data_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [ILEN-1:0] inst_data_o,
    output logic [N-1:0]    inst_pc_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [N-1:0]    pc_q, pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [ILEN-1:0] data_q [DEPTH];
    logic [N-1:0]    qpc_q  [DEPTH];
    logic [N-1:0]    tag_q  [DEPTH];

    logic [CW:0] inflight;
    logic        req_fire, rsp_accept, deq;

    // Queued plus outstanding fetches never exceed DEPTH, so a response always has a slot.
    assign inflight         = {1'b0, count_q} + {1'b0, out_q};
    assign imem_req_valid_o = rst_ni && !redirect_valid_i && (inflight < (CW + 1)'(DEPTH));
    assign imem_req_addr_o  = pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;
    assign rsp_accept       = imem_rsp_valid_i && !redirect_valid_i && (drop_q == '0);

    assign inst_valid_o = (count_q != '0) && !redirect_valid_i;
    assign inst_data_o  = data_q[rd_ptr_q];
    assign inst_pc_o    = qpc_q[rd_ptr_q];
    assign deq          = inst_valid_o && inst_ready_i;

    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        out_d    = out_q;
        drop_d   = drop_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        tag_rd_d = tag_rd_q;
        tag_wr_d = tag_wr_q;
        if (redirect_valid_i) begin
            // Every request still in flight after this edge belongs to the old path.
            pc_d     = redirect_pc_i;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            tag_rd_d = '0;
            tag_wr_d = '0;
            out_d    = out_q - CW'(imem_rsp_valid_i);
            drop_d   = out_q - CW'(imem_rsp_valid_i);
        end else begin
            out_d = out_q + CW'(req_fire) - CW'(imem_rsp_valid_i);
            if (req_fire) begin
                pc_d     = pc_q + N'(4);
                tag_wr_d = tag_wr_q + PW'(1);
            end
            if (imem_rsp_valid_i && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (rsp_accept) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                tag_rd_d = tag_rd_q + PW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(rsp_accept) - CW'(deq);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q     <= RESET_PC;
            count_q  <= '0;
            out_q    <= '0;
            drop_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            tag_rd_q <= '0;
            tag_wr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            tag_rd_q <= tag_rd_d;
            tag_wr_q <= tag_wr_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                qpc_q[i]  <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            if (req_fire) begin
                tag_q[tag_wr_q] <= pc_q;
            end
            if (rsp_accept) begin
                data_q[wr_ptr_q] <= imem_rsp_data_i;
                qpc_q[wr_ptr_q]  <= tag_q[tag_rd_q];
            end
        end
    end

    // A response with nothing outstanding means the memory side broke ordering.
    assert property (@(posedge clk_i) disable iff (!rst_ni) imem_rsp_valid_i |-> out_q != '0);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table, directed corner sequences and random traffic,
// all checked against a queue-based reference model of the fetch pipeline.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redir = 1'b0;
    logic [63:0] rpc = '0;
    logic        rq_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        i_ready = 1'b0;
    logic        rq_valid, i_valid;
    logic [63:0] rq_addr, i_pc;
    logic [31:0] i_data;

    logic        rst8_n = 1'b0;
    logic        rq_ready8 = 1'b0;
    logic        rv8, iv8;
    logic [7:0]  ra8, ip8;
    logic [31:0] id8;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk_i(clk), .rst_ni(rst_n), .redirect_valid_i(redir), .redirect_pc_i(rpc),
        .imem_req_valid_o(rq_valid), .imem_req_ready_i(rq_ready), .imem_req_addr_o(rq_addr),
        .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
        .inst_valid_o(i_valid), .inst_ready_i(i_ready), .inst_data_o(i_data), .inst_pc_o(i_pc)
    );

    fetch_queue #(.N(8), .ILEN(32), .DEPTH(4), .RESET_PC(8'hF8)) dut8 (
        .clk_i(clk), .rst_ni(rst8_n), .redirect_valid_i(1'b0), .redirect_pc_i(8'h00),
        .imem_req_valid_o(rv8), .imem_req_ready_i(rq_ready8), .imem_req_addr_o(ra8),
        .imem_rsp_valid_i(1'b0), .imem_rsp_data_i(32'h0),
        .inst_valid_o(iv8), .inst_ready_i(1'b0), .inst_data_o(id8), .inst_pc_o(ip8)
    );

    typedef struct { logic [63:0] pc; logic [31:0] data; } ent_t;
    typedef struct { logic [63:0] pc; bit sq; } req_t;
    typedef struct {
        bit rr; bit ir; bit rs;
        bit e_rv; logic [63:0] e_addr; bit e_iv; logic [63:0] e_pc;
    } vec_t;

    ent_t        mq[$];
    req_t        mo[$];
    logic [63:0] mpc;
    logic [63:0] mem[$];

    int errors = 0;
    int checks = 0;
    int nreq;
    bit got_pop;
    logic [63:0] first_pop;
    logic [31:0] first_data;
    bit s_rv, s_iv;
    logic [63:0] s_addr, s_pc;

    function automatic logic [31:0] mdata(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit rd, input logic [63:0] tgt, input bit rr, input bit ir,
                       input bit rs);
        bit exp_rv, exp_iv, mfire, dfire, dfire_dut, rsv;
        logic [63:0] daddr;
        req_t r;
        redir = rd; rpc = tgt; rq_ready = rr; i_ready = ir;
        rsv = rs && (mem.size() > 0);
        rsp_valid = rsv;
        rsp_data = rsv ? mdata(mem[0]) : 32'h0;
        #3;
        exp_rv = !rd && (mq.size() + mo.size() < 4);
        exp_iv = !rd && (mq.size() != 0);
        check("req_valid", 64'(rq_valid), 64'(exp_rv));
        check("req_addr", rq_addr, mpc);
        check("inst_valid", 64'(i_valid), 64'(exp_iv));
        if (exp_iv) begin
            check("inst_pc", i_pc, mq[0].pc);
            check("inst_data", 64'(i_data), 64'(mq[0].data));
        end
        s_rv = rq_valid; s_addr = rq_addr; s_iv = i_valid; s_pc = i_pc;
        mfire = exp_rv && rr;
        dfire = exp_iv && ir;
        dfire_dut = i_valid && ir;
        daddr = rq_addr;
        if (rq_valid && rr) nreq++;
        if (dfire_dut && !got_pop) begin
            got_pop = 1'b1; first_pop = i_pc; first_data = i_data;
        end
        @(posedge clk);
        if (dfire) void'(mq.pop_front());
        if (rsv) begin
            void'(mem.pop_front());
            if (mo.size() > 0) begin
                r = mo.pop_front();
                if (!r.sq && !rd) mq.push_back('{pc: r.pc, data: mdata(r.pc)});
            end
        end
        if (rq_valid && rr) mem.push_back(daddr);
        if (mfire) begin
            mo.push_back('{pc: mpc, sq: 1'b0});
            mpc = mpc + 64'd4;
        end
        if (rd) begin
            mq.delete();
            foreach (mo[i]) mo[i].sq = 1'b1;
            mpc = tgt;
        end
        #1;
    endtask

    task automatic do_reset();
        redir = 1'b0; rq_ready = 1'b0; i_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        rst_n = 1'b0;
        #1;
        check("rst_req_valid", 64'(rq_valid), 64'd0);
        check("rst_req_addr", rq_addr, 64'd0);
        check("rst_inst_valid", 64'(i_valid), 64'd0);
        check("rst_inst_data", 64'(i_data), 64'd0);
        check("rst_inst_pc", i_pc, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete(); mo.delete(); mem.delete();
        mpc = 64'd0;
    endtask

    vec_t tbl[10];
    logic [7:0] addr8[4];

    initial begin
        tbl[0] = '{1, 1, 1, 1, 64'd0,  0, 64'd0};
        tbl[1] = '{1, 1, 1, 1, 64'd4,  0, 64'd0};
        tbl[2] = '{1, 1, 1, 1, 64'd8,  1, 64'd0};
        tbl[3] = '{1, 1, 1, 1, 64'd12, 1, 64'd4};
        tbl[4] = '{0, 1, 1, 1, 64'd16, 1, 64'd8};
        tbl[5] = '{0, 1, 1, 1, 64'd16, 1, 64'd12};
        tbl[6] = '{0, 1, 1, 1, 64'd16, 0, 64'd0};
        tbl[7] = '{1, 1, 1, 1, 64'd16, 0, 64'd0};
        tbl[8] = '{1, 1, 1, 1, 64'd20, 0, 64'd0};
        tbl[9] = '{1, 1, 1, 1, 64'd24, 1, 64'd16};
        addr8[0] = 8'hF8; addr8[1] = 8'hFC; addr8[2] = 8'h00; addr8[3] = 8'h04;

        // Streaming fill, then a request stall holding the address at 0x10.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 64'd0, tbl[i].rr, tbl[i].ir, tbl[i].rs);
            check($sformatf("vec%0d_req_valid", i), 64'(s_rv), 64'(tbl[i].e_rv));
            check($sformatf("vec%0d_req_addr", i), s_addr, tbl[i].e_addr);
            check($sformatf("vec%0d_inst_valid", i), 64'(s_iv), 64'(tbl[i].e_iv));
            if (tbl[i].e_iv) check($sformatf("vec%0d_inst_pc", i), s_pc, tbl[i].e_pc);
        end

        // Decode stalled: credit limit caps requests at DEPTH, one pop frees one credit.
        do_reset();
        nreq = 0;
        for (int i = 0; i < 10; i++) cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
        check("credit_limit_reqs", 64'(nreq), 64'd4);
        nreq = 0;
        cyc(1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
        check("one_pop_one_req", 64'(nreq), 64'd1);

        // Three requests outstanding, then redirect: their responses must be squashed.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
        got_pop = 1'b0;
        cyc(1'b1, 64'h200, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20 && !got_pop; i++) cyc(1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
        check("redir_got_inst", 64'(got_pop), 64'd1);
        check("redir_first_pc", first_pop, 64'h200);
        check("redir_first_data", 64'(first_data), 64'(mdata(64'h200)));

        // Redirect colliding with a response and a decode pop.
        for (int i = 0; i < 4; i++) cyc(1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
        got_pop = 1'b0;
        cyc(1'b1, 64'h300, 1'b1, 1'b1, 1'b1);
        check("redir_rsp_inst_valid", 64'(s_iv), 64'd0);
        check("redir_rsp_req_valid", 64'(s_rv), 64'd0);
        for (int i = 0; i < 20 && !got_pop; i++) cyc(1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
        check("redir2_first_pc", first_pop, 64'h300);

        // Random traffic; mid-stream reset follows via do_reset.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 16) == 0, {$urandom, $urandom & 32'hFFFF_FFFC},
                1'($urandom), 1'($urandom), 1'($urandom));
        end
        do_reset();
        cyc(1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
        check("post_reset_first_addr", s_addr, 64'd0);

        // 8-bit PC wrap and mid-stream reset on the narrow instance.
        rst8_n = 1'b1; rq_ready8 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #3;
            if (i < 4) begin
                check($sformatf("wrap%0d_valid", i), 64'(rv8), 64'd1);
                check($sformatf("wrap%0d_addr", i), 64'(ra8), 64'(addr8[i]));
            end else begin
                check($sformatf("wrap%0d_valid", i), 64'(rv8), 64'd0);
            end
            @(posedge clk);
            #1;
        end
        #3;
        rst8_n = 1'b0;
        #1;
        check("n8_rst_valid", 64'(rv8), 64'd0);
        check("n8_rst_addr", 64'(ra8), 64'hF8);
        check("n8_rst_inst_valid", 64'(iv8), 64'd0);
        check("n8_rst_inst_pc", 64'(ip8), 64'd0);
        check("n8_rst_inst_data", 64'(id8), 64'd0);
        @(posedge clk);
        #1;
        rst8_n = 1'b1;
        #3;
        check("n8_first_valid", 64'(rv8), 64'd1);
        check("n8_first_addr", 64'(ra8), 64'hF8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
